// File: rtl/ad9866_rx_agc.sv
// Receive AGC for the AD9866: windowed clip/level evaluation drives a gain code,
// which is handed to the SPI controller over a req/ack handshake.
module ad9866_rx_agc #(
  parameter int GAIN_W    = 6,
  parameter int GAIN_MIN  = 0,
  parameter int GAIN_MAX  = 60,
  parameter int GAIN_INIT = 40,
  parameter int DEC_STEP  = 3,
  parameter int WINDOW    = 76800,
  parameter int HANG      = 8,
  parameter int SETTLE    = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              agc_en,
  input  logic [GAIN_W-1:0] gain_manual,
  input  logic              rxclip,
  input  logic              rxgoodlvl,
  output logic              rxclrstatus,
  output logic [GAIN_W-1:0] gain,
  output logic              gain_req,
  input  logic              gain_ack,
  output logic              gain_at_lim
);

  localparam int WIN_W  = $clog2(WINDOW);
  localparam int HANG_W = $clog2(HANG + 1);
  localparam int SET_W  = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {ST_COUNT, ST_EVAL, ST_REQ, ST_SETTLE} state_t;

  state_t              state_q, state_d;
  logic [GAIN_W-1:0]   gain_q, gain_d, gain_nxt;
  logic                req_q, req_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [HANG_W-1:0]   hang_q, hang_d;
  logic [SET_W-1:0]    set_q, set_d;

  function automatic logic [GAIN_W-1:0] clamp_gain(input logic [GAIN_W-1:0] g);
    logic signed [GAIN_W:0] v;
    v = $signed({1'b0, g});
    if (v < $signed((GAIN_W+1)'(GAIN_MIN)))      return GAIN_W'(GAIN_MIN);
    else if (v > $signed((GAIN_W+1)'(GAIN_MAX))) return GAIN_W'(GAIN_MAX);
    else                                         return g;
  endfunction

  function automatic logic [GAIN_W-1:0] sat_dec(input logic [GAIN_W-1:0] g);
    logic signed [GAIN_W:0] v;
    v = $signed({1'b0, g}) - $signed((GAIN_W+1)'(DEC_STEP));
    if (v < $signed((GAIN_W+1)'(GAIN_MIN))) return GAIN_W'(GAIN_MIN);
    else                                    return v[GAIN_W-1:0];
  endfunction

  function automatic logic [GAIN_W-1:0] sat_inc(input logic [GAIN_W-1:0] g);
    logic signed [GAIN_W:0] v;
    v = $signed({1'b0, g}) + $signed((GAIN_W+1)'(1));
    if (v > $signed((GAIN_W+1)'(GAIN_MAX))) return GAIN_W'(GAIN_MAX);
    else                                    return v[GAIN_W-1:0];
  endfunction

  // Reset parks in REQ with gain_req low so the initial gain is programmed once rst drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_REQ;
      gain_q  <= GAIN_W'(GAIN_INIT);
      req_q   <= 1'b0;
      win_q   <= '0;
      hang_q  <= '0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      req_q   <= req_d;
      win_q   <= win_d;
      hang_q  <= hang_d;
      set_q   <= set_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    win_d    = win_q;
    hang_d   = hang_q;
    set_d    = set_q;
    gain_nxt = gain_q;
    case (state_q)
      ST_COUNT: begin
        win_d = win_q + WIN_W'(1);
        // Manual mode keeps the window idle so re-enabling the loop starts fresh.
        if (!agc_en) begin
          win_d  = '0;
          hang_d = '0;
          if (clamp_gain(gain_manual) != gain_q) begin
            gain_d  = clamp_gain(gain_manual);
            state_d = ST_REQ;
          end
        end else if (win_q == WIN_W'(WINDOW - 1)) begin
          win_d   = '0;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (rxclip) begin
          gain_nxt = sat_dec(gain_q);
          hang_d   = '0;
        end else if (rxgoodlvl) begin
          hang_d = '0;
        end else if (hang_q == HANG_W'(HANG - 1)) begin
          gain_nxt = sat_inc(gain_q);
          hang_d   = '0;
        end else begin
          hang_d = hang_q + HANG_W'(1);
        end
        if (gain_nxt != gain_q) begin
          gain_d  = gain_nxt;
          state_d = ST_REQ;
        end else begin
          state_d = ST_COUNT;
        end
      end
      ST_REQ: begin
        if (gain_ack) begin
          set_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        set_d = set_q + SET_W'(1);
        if (set_q == SET_W'(SETTLE - 1)) begin
          win_d   = '0;
          state_d = ST_COUNT;
        end
      end
      default: state_d = ST_REQ;
    endcase
    req_d = (state_d == ST_REQ);
  end

  always_comb begin
    rxclrstatus = (state_q == ST_EVAL) ||
                  ((state_q == ST_SETTLE) && (set_q == SET_W'(SETTLE - 1)));
    gain_at_lim = (gain_q == GAIN_W'(GAIN_MIN)) || (gain_q == GAIN_W'(GAIN_MAX));
  end

  assign gain     = gain_q;
  assign gain_req = req_q;

endmodule

// File: tb/tb_ad9866_rx_agc.sv
// Directed bench for ad9866_rx_agc with a short window, hang and settle time.
module tb_ad9866_rx_agc;

  localparam int GW     = 6;
  localparam int WINDOW = 16;
  localparam int HANG   = 4;
  localparam int SETTLE = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          agc_en = 1'b1;
  logic [GW-1:0] gain_manual = '0;
  logic          rxclip = 1'b0;
  logic          rxgoodlvl = 1'b0;
  logic          gain_ack = 1'b0;
  logic          rxclrstatus;
  logic [GW-1:0] gain;
  logic          gain_req;
  logic          gain_at_lim;

  int checks = 0;
  int errors = 0;

  ad9866_rx_agc #(
    .GAIN_W(GW), .GAIN_MIN(0), .GAIN_MAX(60), .GAIN_INIT(40), .DEC_STEP(3),
    .WINDOW(WINDOW), .HANG(HANG), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .agc_en(agc_en), .gain_manual(gain_manual),
    .rxclip(rxclip), .rxgoodlvl(rxgoodlvl), .rxclrstatus(rxclrstatus),
    .gain(gain), .gain_req(gain_req), .gain_ack(gain_ack), .gain_at_lim(gain_at_lim)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entered in REQ; leaves on the first COUNT cycle with a fresh window.
  task automatic ack_and_settle(input string tag);
    gain_ack = 1'b1;
    tick;
    gain_ack = 1'b0;
    chk({tag, "_req_drop"}, gain_req, 0);
    repeat (SETTLE - 2) tick;
    chk({tag, "_settle_noclr"}, rxclrstatus, 0);
    tick;
    chk({tag, "_settle_clr"}, rxclrstatus, 1);
    tick;
    chk({tag, "_count_noclr"}, rxclrstatus, 0);
  endtask

  // Entered on the first COUNT cycle of a window; returns one cycle after EVAL.
  task automatic window(input logic clip, input logic good, input int eg, input int er,
                        input string tag);
    rxclip    = clip;
    rxgoodlvl = good;
    repeat (WINDOW - 1) tick;
    chk({tag, "_pre_eval_clr"}, rxclrstatus, 0);
    tick;
    chk({tag, "_eval_clr"}, rxclrstatus, 1);
    tick;
    rxclip    = 1'b0;
    rxgoodlvl = 1'b0;
    chk({tag, "_gain"}, gain, eg);
    chk({tag, "_req"}, gain_req, er);
  endtask

  typedef struct {
    logic clip;
    logic good;
    int   exp_gain;
    int   exp_req;
    int   hold;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 37, 1, 5};
    tbl[1]  = '{1'b0, 1'b0, 37, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 37, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 37, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 38, 1, 0};
    tbl[5]  = '{1'b0, 1'b0, 38, 0, 0};
    tbl[6]  = '{1'b0, 1'b1, 38, 0, 0};
    tbl[7]  = '{1'b0, 1'b0, 38, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 38, 0, 0};
    tbl[9]  = '{1'b0, 1'b0, 38, 0, 0};
    tbl[10] = '{1'b0, 1'b0, 39, 1, 0};

    // Reset and initial programming
    repeat (3) tick;
    chk("rst_gain", gain, 40);
    chk("rst_req", gain_req, 0);
    chk("rst_clr", rxclrstatus, 0);
    rst = 1'b0;
    tick;
    chk("init_req_c1", gain_req, 1);
    chk("init_gain_c1", gain, 40);
    chk("init_lim", gain_at_lim, 0);
    repeat (2) tick;
    chk("init_req_c3", gain_req, 1);
    ack_and_settle("init");

    // Clip, hang and good-level windows
    for (int i = 0; i < 11; i++) begin
      window(tbl[i].clip, tbl[i].good, tbl[i].exp_gain, tbl[i].exp_req, $sformatf("vec%0d", i));
      if (tbl[i].hold > 0) begin
        rxclip = 1'b1;
        repeat (tbl[i].hold) tick;
        rxclip = 1'b0;
        chk($sformatf("vec%0d_hold_gain", i), gain, tbl[i].exp_gain);
        chk($sformatf("vec%0d_hold_req", i), gain_req, 1);
      end
      if (tbl[i].exp_req != 0) ack_and_settle($sformatf("vec%0d", i));
    end

    // Climb to the ceiling one code per HANG quiet windows
    for (int g = 40; g <= 60; g++) begin
      for (int k = 0; k < HANG - 1; k++) window(1'b0, 1'b0, g - 1, 0, $sformatf("climbq%0d", g));
      window(1'b0, 1'b0, g, 1, $sformatf("climb%0d", g));
      ack_and_settle($sformatf("climb%0d", g));
    end
    chk("ceil_lim", gain_at_lim, 1);
    for (int k = 0; k < HANG; k++) window(1'b0, 1'b0, 60, 0, "ceil");

    // Manual jump to 4, then clip down to the floor
    agc_en      = 1'b0;
    gain_manual = 6'd4;
    tick;
    chk("man4_gain", gain, 4);
    chk("man4_req", gain_req, 1);
    ack_and_settle("man4");
    agc_en = 1'b1;
    window(1'b1, 1'b0, 1, 1, "floor1");
    ack_and_settle("floor1");
    window(1'b1, 1'b0, 0, 1, "floor0");
    ack_and_settle("floor0");
    chk("floor_lim", gain_at_lim, 1);
    window(1'b1, 1'b0, 0, 0, "floor_hold");

    // Manual clamp and a manual change while a request is pending
    agc_en      = 1'b0;
    gain_manual = 6'd63;
    tick;
    chk("man63_gain", gain, 60);
    chk("man63_req", gain_req, 1);
    gain_manual = 6'd10;
    repeat (3) tick;
    chk("man_pend_gain", gain, 60);
    chk("man_pend_req", gain_req, 1);
    ack_and_settle("man63");
    chk("man_after_settle_gain", gain, 60);
    tick;
    chk("man10_gain", gain, 10);
    chk("man10_req", gain_req, 1);
    ack_and_settle("man10");
    repeat (4) tick;
    chk("man10_once_req", gain_req, 0);
    chk("man10_once_gain", gain, 10);

    // Reset while a request is outstanding
    gain_manual = 6'd37;
    tick;
    chk("pre_rst_gain", gain, 37);
    chk("pre_rst_req", gain_req, 1);
    rst = 1'b1;
    tick;
    chk("mid_rst_gain", gain, 40);
    chk("mid_rst_req", gain_req, 0);
    chk("mid_rst_clr", rxclrstatus, 0);
    tick;
    rst = 1'b0;
    tick;
    chk("post_rst_req", gain_req, 1);
    chk("post_rst_gain", gain, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
